// File: rtl/fp_norm_shift_seq.sv
// Sequential pre-normalizer: left-shifts the raw add-stage sum until its MSB is set.
// Optional macro FP_NORM_DUAL_SHIFT_EN allows two-bit shifts per cycle when safe.
//
// state   | meaning
// S_IDLE  | ready to accept a new sum/exponent pair
// S_SHIFT | shifting working sum toward bit SUM_W-1
// S_DONE  | result presented, waiting for downstream to accept
module fp_norm_shift_seq #(
   parameter int SUM_W     = 9,
   parameter int SHIFT_W   = 3,
   parameter int MAX_SHIFT = 7
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [SUM_W-1:0]   sum_in,
   input  logic [2:0]         cexp_in,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [SUM_W-1:0]   pssum,
   output logic [SHIFT_W-1:0] shift,
   output logic [2:0]         cexp_out,
   output logic               zero_sum,
   output logic               sat
);

   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

   state_t               state_q, state_d;
   logic [SUM_W-1:0]     work_q, work_d;
   logic [SHIFT_W-1:0]   cnt_q, cnt_d;
   logic [2:0]           cexp_q, cexp_d;
   logic                 zero_q, zero_d;
   logic                 sat_q, sat_d;

`ifdef FP_NORM_DUAL_SHIFT_EN
   logic [SHIFT_W:0]     remain;
   // Shifts still available before saturation; cnt_q never exceeds MAX_SHIFT.
   assign remain = (SHIFT_W+1)'(MAX_SHIFT) - {1'b0, cnt_q};
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         work_q  <= '0;
         cnt_q   <= '0;
         cexp_q  <= '0;
         zero_q  <= 1'b0;
         sat_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         work_q  <= work_d;
         cnt_q   <= cnt_d;
         cexp_q  <= cexp_d;
         zero_q  <= zero_d;
         sat_q   <= sat_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      work_d    = work_q;
      cnt_d     = cnt_q;
      cexp_d    = cexp_q;
      zero_d    = zero_q;
      sat_d     = sat_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state_q)
         S_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               work_d  = sum_in;
               cexp_d  = cexp_in;
               cnt_d   = '0;
               zero_d  = 1'b0;
               sat_d   = 1'b0;
               state_d = S_SHIFT;
            end
         end
         S_SHIFT: begin
            if (work_q == '0) begin
               zero_d  = 1'b1;
               cnt_d   = '0;
               work_d  = '0;
               state_d = S_DONE;
            end else if (work_q[SUM_W-1]) begin
               state_d = S_DONE;
            end else if (cnt_q == SHIFT_W'(MAX_SHIFT)) begin
               sat_d   = 1'b1;
               state_d = S_DONE;
            end else begin
`ifdef FP_NORM_DUAL_SHIFT_EN
               // MSB already known clear; two-bit step only if the next bit is clear too.
               if (!work_q[SUM_W-2] && remain >= (SHIFT_W+1)'(2)) begin
                  work_d = work_q << 2;
                  cnt_d  = cnt_q + SHIFT_W'(2);
               end else begin
                  work_d = work_q << 1;
                  cnt_d  = cnt_q + SHIFT_W'(1);
               end
`else
               work_d = work_q << 1;
               cnt_d  = cnt_q + SHIFT_W'(1);
`endif
            end
         end
         S_DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign pssum    = work_q;
   assign shift    = cnt_q;
   assign cexp_out = cexp_q;
   assign zero_sum = zero_q;
   assign sat      = sat_q;

endmodule
